// File: rtl/ethernet_pkg.sv
// Shared encodings, CRC-32 constants and the nibble-wide CRC step for the Ethernet MII datapaths.
package ethernet_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_SFD      = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_PAD      = 3'd4;
  localparam logic [2:0] ST_FCS      = 3'd5;
  localparam logic [2:0] ST_ABORT    = 3'd6;
  localparam logic [2:0] ST_IFG      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PREAMBLE = ST_PREAMBLE,
    S_SFD      = ST_SFD,
    S_DATA     = ST_DATA,
    S_PAD      = ST_PAD,
    S_FCS      = ST_FCS,
    S_ABORT    = ST_ABORT,
    S_IFG      = ST_IFG
  } tx_state_e;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD      = 4'hD;

  // Reflected CRC-32 advanced by one nibble, bit 0 of the nibble first.
  function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC_POLY_REFL;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_nibble.sv
// Combinational reflected CRC-32 update over one MII nibble; shared by the TX and RX paths.
module crc32_nibble
  import ethernet_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  nib_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_nib_step(crc_i, nib_i);

endmodule

// File: rtl/ethernet_mii_tx.sv
// MII transmit framer: preamble, SFD, payload, optional pad, FCS and inter-frame gap.
// Define ETHERNET_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes before the FCS.
module ethernet_mii_tx
  import ethernet_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBBLES = 15,
  parameter int unsigned IFG_NIBBLES      = 24,
  parameter int unsigned MIN_FRAME        = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic [3:0] mii_txd_o,
  output logic       mii_tx_en_o,
  output logic       mii_tx_er_o,
  output logic       busy_o,
  output logic       underrun_o
);

`ifdef ETHERNET_TX_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  localparam logic [7:0]  PRE_LAST    = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0]  IFG_LAST    = 8'(IFG_NIBBLES - 1);
  localparam logic [7:0]  FCS_LAST    = 8'd7;
  localparam logic [15:0] MIN_FRAME_W = 16'(MIN_FRAME);

  tx_state_e   state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;

  logic [31:0] crc_upd;
  logic [15:0] byte_cnt_inc;
  logic        accept;
  logic        pad_req;
  logic [31:0] fcs_word;

  // The nibble on the wire this cycle is the one folded into the CRC.
  crc32_nibble u_crc (
    .crc_i (crc_q),
    .nib_i (txd_q),
    .crc_o (crc_upd)
  );

  assign tx_ready_o   = !reset && ((state_q == S_IDLE) ||
                                   ((state_q == S_DATA) && phase_q && !last_q));
  assign accept       = tx_valid_i && tx_ready_o;
  assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign pad_req      = PAD_EN && (byte_cnt_inc < MIN_FRAME_W);

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    crc_d      = crc_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_PREAMBLE;
          data_d     = tx_data_i;
          last_d     = tx_last_i;
          crc_d      = CRC_INIT;
          byte_cnt_d = 16'd0;
          cnt_d      = 8'd0;
          phase_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_SFD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SFD: begin
        state_d = S_DATA;
        phase_d = 1'b0;
      end
      S_DATA: begin
        crc_d = crc_upd;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          byte_cnt_d = byte_cnt_inc;
          if (!last_q) begin
            if (tx_valid_i) begin
              data_d = tx_data_i;
              last_d = tx_last_i;
            end else begin
              state_d = S_ABORT;
            end
          end else if (pad_req) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FCS;
            cnt_d   = 8'd0;
          end
        end
      end
`ifdef ETHERNET_TX_PAD_EN
      S_PAD: begin
        crc_d = crc_upd;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          byte_cnt_d = byte_cnt_inc;
          if (byte_cnt_inc >= MIN_FRAME_W) begin
            state_d = S_FCS;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_PAD;
          end
        end
      end
`endif
      S_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = S_IFG;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ABORT: begin
        state_d = S_IFG;
        cnt_d   = 8'd0;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state they describe.
  always_comb begin
    txd_d      = 4'h0;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    fcs_word   = ~crc_d;
    busy_d     = (state_d != S_IDLE);
    underrun_d = (state_d == S_ABORT);
    case (state_d)
      S_PREAMBLE: begin
        txd_d   = NIB_PREAMBLE;
        tx_en_d = 1'b1;
      end
      S_SFD: begin
        txd_d   = NIB_SFD;
        tx_en_d = 1'b1;
      end
      S_DATA: begin
        txd_d   = phase_d ? data_d[7:4] : data_d[3:0];
        tx_en_d = 1'b1;
      end
      S_PAD: begin
        txd_d   = 4'h0;
        tx_en_d = 1'b1;
      end
      S_FCS: begin
        txd_d   = fcs_word[{cnt_d[2:0], 2'b00} +: 4];
        tx_en_d = 1'b1;
      end
      S_ABORT: begin
        txd_d   = 4'h0;
        tx_en_d = 1'b1;
        tx_er_d = 1'b1;
      end
      default: begin
        txd_d   = 4'h0;
        tx_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 16'd0;
      data_q     <= 8'd0;
      last_q     <= 1'b0;
      crc_q      <= CRC_INIT;
      txd_q      <= 4'h0;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign mii_txd_o   = txd_q;
  assign mii_tx_en_o = tx_en_q;
  assign mii_tx_er_o = tx_er_q;
  assign busy_o      = busy_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_ethernet_mii_tx.sv
// Directed self-checking bench for ethernet_mii_tx; pad-dependent scenarios follow ETHERNET_TX_PAD_EN.
module tb_ethernet_mii_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

`ifdef ETHERNET_TX_PAD_EN
  localparam int FRAME9_EN = 144;
`else
  localparam int FRAME9_EN = 42;
`endif

  ethernet_mii_tx dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_last_i   (tx_last),
    .tx_ready_o  (tx_ready),
    .mii_txd_o   (mii_txd),
    .mii_tx_en_o (mii_tx_en),
    .mii_tx_er_o (mii_tx_er),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  always #20 clk = ~clk;

  // Wire monitor: records every transmitted nibble and edge timestamps, sampled on the falling edge.
  logic [3:0] nibs[$];
  int rise_q[$], fall_q[$], idle_q[$], er_q[$], und_q[$];
  int en_cycles = 0;
  int cyc = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      prev_en   <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (mii_tx_en) begin
        nibs.push_back(mii_txd);
        en_cycles <= en_cycles + 1;
      end
      if (mii_tx_en && !prev_en) rise_q.push_back(cyc);
      if (!mii_tx_en && prev_en) fall_q.push_back(cyc);
      if (!busy && prev_busy) idle_q.push_back(cyc);
      if (mii_tx_er) er_q.push_back(cyc);
      if (underrun) und_q.push_back(cyc);
      prev_en   <= mii_tx_en;
      prev_busy <= busy;
    end
  end

  logic [7:0] mem [0:15];

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // CRC register (no final inversion) over nibble pairs nibs[from .. to-1].
  function automatic logic [31:0] crc_over(input int from, input int to);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = from; k + 1 < to; k += 2) c = crc_byte(c, {nibs[k+1], nibs[k]});
    return c;
  endfunction

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
  endtask

  task automatic send(input int n, input bit mark_last);
    int w;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      tx_data  = mem[i];
      tx_valid = 1'b1;
      tx_last  = mark_last && (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!tx_ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (!tx_ready) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0d not accepted within %0d cycles", i, w);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still high after %0d cycles", w);
    end
    @(negedge clk);
  endtask

  task automatic check_preamble(input string tag, input int s);
    int bad;
    bad = 0;
    for (int i = 0; i < 15; i++) if (nibs[s+i] !== 4'h5) bad++;
    if (nibs[s+15] !== 4'hD) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_preamble_sfd: %0d bad nibbles, required 15x5 then D", tag, bad);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, mii_txd, mii_tx_en, mii_tx_er, busy, underrun} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {tx_ready, mii_txd, mii_tx_en, mii_tx_er, busy, underrun});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_basic_frame();
    int s, e0, bad;
    logic [31:0] fcs;
    logic [3:0] exp;
    load_123456789();
    s  = nibs.size();
    e0 = en_cycles;
    send(9, 1'b1);
    wait_idle();
    checks++;
    if (en_cycles - e0 != 42) begin
      errors++;
      $display("FAIL basic_en_len: got %0d cycles required 42", en_cycles - e0);
    end
    if (nibs.size() - s >= 42) begin
      check_preamble("basic", s);
      bad = 0;
      for (int i = 0; i < 9; i++) begin
        if (nibs[s+16+2*i] !== mem[i][3:0]) bad++;
        if (nibs[s+17+2*i] !== mem[i][7:4]) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL basic_data: %0d bad data nibbles, required 0", bad);
      end
      fcs = 32'hCBF43926;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        exp = fcs[4*i +: 4];
        if (nibs[s+34+i] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL basic_fcs: %0d bad FCS nibbles, required sequence 6,2,9,3,4,F,B,C", bad);
      end
    end
    checks++;
    if (idle_q[$] - fall_q[$] != 24) begin
      errors++;
      $display("FAIL basic_ifg: got %0d idle cycles required 24", idle_q[$] - fall_q[$]);
    end
  endtask

  task automatic test_pad();
    int s, e0, bad;
    load_123456789();
    s  = nibs.size();
    e0 = en_cycles;
    send(9, 1'b1);
    wait_idle();
    checks++;
    if (en_cycles - e0 != 144) begin
      errors++;
      $display("FAIL pad_en_len: got %0d cycles required 144", en_cycles - e0);
    end
    if (nibs.size() - s >= 144) begin
      bad = 0;
      for (int i = 34; i < 136; i++) if (nibs[s+i] !== 4'h0) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL pad_zero: %0d nonzero pad nibbles required 0", bad);
      end
      checks++;
      if (crc_over(s + 16, s + 144) !== 32'hDEBB20E3) begin
        errors++;
        $display("FAIL pad_residue: got %h required DEBB20E3", crc_over(s + 16, s + 144));
      end
    end
  endtask

  task automatic test_underrun();
    int s, e0, r0, u0;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    s  = nibs.size();
    e0 = en_cycles;
    r0 = er_q.size();
    u0 = und_q.size();
    send(2, 1'b0);
    wait_idle();
    checks++;
    if (er_q.size() - r0 != 1 || und_q.size() - u0 != 1) begin
      errors++;
      $display("FAIL underrun_count: tx_er cycles %0d underrun pulses %0d required 1 1",
               er_q.size() - r0, und_q.size() - u0);
    end else begin
      checks++;
      if (er_q[r0] != und_q[u0]) begin
        errors++;
        $display("FAIL underrun_align: tx_er at %0d underrun at %0d required equal", er_q[r0], und_q[u0]);
      end
    end
    checks++;
    if (en_cycles - e0 != 21) begin
      errors++;
      $display("FAIL underrun_en_len: got %0d cycles required 21 (no FCS)", en_cycles - e0);
    end
    checks++;
    if (nibs.size() > s && nibs[$] !== 4'h0) begin
      errors++;
      $display("FAIL underrun_txd: abort nibble %h required 0", nibs[$]);
    end
    checks++;
    if (idle_q[$] - fall_q[$] != 24) begin
      errors++;
      $display("FAIL underrun_ifg: got %0d idle cycles required 24", idle_q[$] - fall_q[$]);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL underrun_ready: got %b required 1", tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    int e0, ra, fa;
    load_123456789();
    e0 = en_cycles;
    ra = rise_q.size();
    fa = fall_q.size();
    send(9, 1'b1);
    send(9, 1'b1);
    wait_idle();
    checks++;
    if (rise_q.size() < ra + 2 || fall_q.size() < fa + 1) begin
      errors++;
      $display("FAIL b2b_frames: rises %0d falls %0d required 2 1", rise_q.size() - ra, fall_q.size() - fa);
    end else if (rise_q[ra+1] - fall_q[fa] != 25) begin
      errors++;
      $display("FAIL b2b_gap: tx_en low %0d cycles required 25", rise_q[ra+1] - fall_q[fa]);
    end
    checks++;
    if (en_cycles - e0 != 2 * FRAME9_EN) begin
      errors++;
      $display("FAIL b2b_en_len: got %0d cycles required %0d", en_cycles - e0, 2 * FRAME9_EN);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    @(posedge clk); #1;
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    tx_last  = 1'b0;
    w = 0;
    @(negedge clk);
    while (!tx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #1;
    tx_data = 8'h22;
    repeat (20) @(negedge clk);
    checks++;
    if (mii_tx_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_active: tx_en=%b busy=%b required 1 1", mii_tx_en, busy);
    end
    #5 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mii_txd, mii_tx_en, mii_tx_er, busy, underrun, tx_ready} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b required 000000000",
               {mii_txd, mii_tx_en, mii_tx_er, busy, underrun, tx_ready});
    end
    tx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || mii_tx_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: tx_ready=%b busy=%b tx_en=%b required 1 0 0", tx_ready, busy, mii_tx_en);
    end
  endtask

  task automatic test_single_byte();
    int s, e0, bad;
    logic [31:0] fcs;
    logic [3:0] exp;
    mem[0] = 8'hA5;
    s  = nibs.size();
    e0 = en_cycles;
    send(1, 1'b1);
    wait_idle();
    checks++;
    if (en_cycles - e0 != 26) begin
      errors++;
      $display("FAIL single_en_len: got %0d cycles required 26", en_cycles - e0);
    end
    if (nibs.size() - s >= 26) begin
      check_preamble("single", s);
      checks++;
      if (nibs[s+16] !== 4'h5 || nibs[s+17] !== 4'hA) begin
        errors++;
        $display("FAIL single_data: got %h,%h required 5,A", nibs[s+16], nibs[s+17]);
      end
      fcs = ~crc_byte(32'hFFFFFFFF, 8'hA5);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        exp = fcs[4*i +: 4];
        if (nibs[s+18+i] !== exp) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_fcs: %0d bad FCS nibbles for CRC %h", bad, fcs);
      end
      checks++;
      if (crc_over(s + 16, s + 26) !== 32'hDEBB20E3) begin
        errors++;
        $display("FAIL single_residue: got %h required DEBB20E3", crc_over(s + 16, s + 26));
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef ETHERNET_TX_PAD_EN
    test_pad();
`else
    test_basic_frame();
`endif
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
`ifndef ETHERNET_TX_PAD_EN
    test_single_byte();
`endif
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
